ov7670_config_seq: RTL and testbench
====================================

# ov7670_config_seq

Walks the OV7670 register-configuration ROM entry by entry and issues one SCCB register write per entry through a valid/ready request port to the SCCB master. Sits directly downstream of the synchronous config ROM, whose address it drives and whose data it consumes, and directly upstream of the SCCB master. It interprets two reserved ROM words: an end marker and a timed delay. It reports `busy`, `done` and `error` to the camera bring-up logic.

## Interface
- `CLK_FREQ_HZ`, 25_000_000: frequency of `clk`, used to derive the delay count.
- `DELAY_MS`, 10: wait length for a delay entry, in milliseconds.
- `DEPTH`, 256: number of ROM entries; `ADDRW = $clog2(DEPTH)` (localparam).
- `clk`, in, 1: single clock. All logic runs on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins a configuration pass. Ignored while `busy`.
- `rom_addr`, out, ADDRW: ROM address. The ROM returns data one cycle after the address is presented.
- `rom_data`, in, 16: ROM word, encoded as {reg[7:0], value[7:0]}.
- `sccb_valid`, out, 1: a write request is pending.
- `sccb_ready`, in, 1: the SCCB master accepts the request.
- `sccb_reg`, out, 8: register address for the write.
- `sccb_val`, out, 8: register value for the write.
- `sccb_done`, in, 1: one-cycle pulse marking the end of the accepted transaction.
- `sccb_nack`, in, 1: slave NACK. Qualified by `sccb_done`.
- `busy`, out, 1: a pass is in progress.
- `done`, out, 1: the last pass completed without error. Sticky until the next `start` or `rst`.
- `error`, out, 1: the last pass aborted. Sticky until the next `start` or `rst`.

## Operation
- **Reserved words** (values in the package):
  - `CFG_END = 16'hFFFF`: end of table.
  - `CFG_DELAY = 16'hFFF0`: wait `DELAY_MS`.
  - Every other word is a register write.
- **States:** IDLE, FETCH, DECODE, SEND, WAIT, DELAY, FIN, ERR.
- **IDLE:** on `start`, set `rom_addr` to 0, clear `done`/`error`/retry count, set `busy`, then go to FETCH.
- **FETCH:** one cycle with `rom_addr` stable, so the ROM can register the word. Then go to DECODE.
- **DECODE:** register `rom_data` and branch:
  - `CFG_END` → FIN.
  - `CFG_DELAY` → DELAY, loading the counter with `CLK_FREQ_HZ/1000*DELAY_MS - 1`.
  - Any other word → SEND, with `sccb_reg`/`sccb_val` taken from the registered word.
- **SEND:**
  - Assert `sccb_valid`. `sccb_reg`/`sccb_val` hold stable while `sccb_valid && !sccb_ready`.
  - On the cycle `sccb_valid && sccb_ready` is true, deassert `sccb_valid` on the next edge and go to WAIT.
- **WAIT:**
  - On `sccb_done && !sccb_nack`: advance the entry.
  - On `sccb_done && sccb_nack`: apply the NACK policy (see Configuration).
- **DELAY:** decrement the counter each cycle. At 0, advance the entry.
- **Advance the entry:**
  - If `rom_addr == DEPTH-1` → FIN. No wrap to 0; a table without an end marker still terminates.
  - Otherwise increment `rom_addr` → FETCH.
- **FIN:** pulse nothing. Set `done`, clear `busy` → IDLE.
- **ERR:** set `error`, clear `busy` → IDLE.
- **Edge cases:**
  - `sccb_done` outside WAIT is ignored.
  - `start` asserted together with `rst`: `rst` wins.
- **Arithmetic:**
  - The delay counter width is `$clog2(CLK_FREQ_HZ/1000*DELAY_MS)`. It is unsigned and saturates at 0.
  - The retry counter is 2 bits.

## Timing
- **Reset values** (on `rst` at any point, including mid-pass; the next cycle is IDLE):
  - `rom_addr=0`, `sccb_valid=0`, `sccb_reg=0`, `sccb_val=0`, `busy=0`, `done=0`, `error=0`.
- **`busy`:** high from the cycle after `start` until the FIN/ERR cycle inclusive.
- **Minimum cost per write entry:** FETCH 1 + DECODE 1 + SEND ≥1, plus SCCB time.
- **Delay entry:** exactly 2 + `CLK_FREQ_HZ/1000*DELAY_MS` cycles from FETCH to the next FETCH.
- **End entry:** `done` rises 2 cycles after FETCH of the end word (DECODE, then FIN).
- **Request port:** `sccb_valid` is never asserted in the same cycle as `rom_addr` changes.

## Configuration
- **`OV7670_CFG_RETRY_EN`**
  - Defined: a NACK re-enters SEND with the same entry, up to 3 retries per entry; the counter is cleared on each advance. A fourth NACK → ERR.
  - Undefined: the first NACK → ERR, and the retry counter is not built.

## Structure
- **Package `ov7670_pkg`:** `CFG_END`, `CFG_DELAY`, `MAX_RETRY = 3`, and the state enum typedef `cfg_state_t`.
- **Sub-module `ov7670_delay_timer`:** a loadable down-counter with `load`, `count` and `expired` (expired at 0), instantiated once.

## Test plan
- Table {0x1280, FFF0, 0x1100, FFFF}, `CLK_FREQ_HZ=1000`, `DELAY_MS=5` → two writes (0x12/0x80, 0x11/0x00), 7 cycles FETCH→FETCH across the delay, `done=1`, `error=0`.
- `sccb_ready` held low for 10 cycles in SEND → `sccb_valid` stays 1 with `sccb_reg`/`sccb_val` unchanged, then one accept only.
- NACK on entry 1:
  - With the macro: 2 NACKs then ACK → 3 transactions with identical reg/val, `done=1`.
  - Without the macro: `error=1`, `busy=0`, no further writes.
- Table with no `CFG_END`, `DEPTH=4` → 4 writes, `rom_addr` stops at 3, `done=1`.
- `rst` asserted in WAIT mid-pass → next cycle all outputs at reset values. A subsequent `start` restarts from address 0.
- `start` pulsed while `busy` → no effect on `rom_addr` or the transaction count.

Source files
------------

// File: rtl/ov7670_pkg.sv
// ov7670_pkg
// Shared definitions for the OV7670 register-configuration sequencer:
//   CFG_END    - reserved ROM word that terminates the table
//   CFG_DELAY  - reserved ROM word that requests a timed wait
//   MAX_RETRY  - NACK retries allowed per entry when retries are built
//   cfg_state_t - sequencer FSM state encoding
package ov7670_pkg;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;
    localparam int unsigned MAX_RETRY = 3;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StSend,
        StWait,
        StDelay,
        StFin,
        StErr
    } cfg_state_t;

endpackage

// File: rtl/ov7670_delay_timer.sv
// ov7670_delay_timer
// Loadable down-counter used for the timed-delay ROM entries.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset (counter cleared to 0)
//   load    - load the counter with `count` this cycle
//   count   - value loaded on `load`
//   expired - counter is at 0
// The counter decrements every cycle it is not loaded and saturates at 0.
module ov7670_delay_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] count,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = count;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/ov7670_config_seq.sv
// ov7670_config_seq
// Walks the OV7670 configuration ROM and issues one SCCB register write per
// entry over a valid/ready request port. Two ROM words are reserved:
// CFG_END stops the pass, CFG_DELAY waits DELAY_MS milliseconds.
//
// Parameters:
//   CLK_FREQ_HZ - clk frequency, used to size the delay wait
//   DELAY_MS    - wait length of a delay entry
//   DEPTH       - number of ROM entries (ADDRW = $clog2(DEPTH))
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   start                - pulse that begins a pass (ignored while busy)
//   rom_addr / rom_data  - synchronous ROM, data one cycle after address
//   sccb_valid/ready     - write request handshake to the SCCB master
//   sccb_reg / sccb_val  - register address / value of the request
//   sccb_done/sccb_nack  - end-of-transaction pulse, NACK qualified by done
//   busy / done / error  - pass status; done and error are sticky
//
// Build option: define OV7670_CFG_RETRY_EN to retry a NACKed write up to
// MAX_RETRY times before aborting; otherwise the first NACK aborts the pass.
module ov7670_config_seq
    import ov7670_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned DELAY_MS    = 10,
    parameter int unsigned DEPTH       = 256,
    localparam int unsigned ADDRW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [ADDRW-1:0] rom_addr,
    input  logic [15:0]      rom_data,
    output logic             sccb_valid,
    input  logic             sccb_ready,
    output logic [7:0]       sccb_reg,
    output logic [7:0]       sccb_val,
    input  logic             sccb_done,
    input  logic             sccb_nack,
    output logic             busy,
    output logic             done,
    output logic             error
);

    // Delay entry spends DELAY_CYC cycles in StDelay (counter N-1 .. 0).
    localparam int unsigned DELAY_CYC = CLK_FREQ_HZ / 1000 * DELAY_MS;
    localparam int unsigned CNTW      = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
    localparam logic [CNTW-1:0]  DELAY_LOAD = CNTW'(DELAY_CYC - 1);
    localparam logic [ADDRW-1:0] LAST_ADDR  = ADDRW'(DEPTH - 1);

    cfg_state_t       state_q, state_d;
    logic [ADDRW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       val_q, val_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             tmr_load;
    logic             tmr_expired;
    logic             advance;

`ifdef OV7670_CFG_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    ov7670_delay_timer #(
        .W(CNTW)
    ) u_delay_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .count  (DELAY_LOAD),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        reg_d      = reg_q;
        val_d      = val_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        tmr_load   = 1'b0;
        advance    = 1'b0;
`ifdef OV7670_CFG_RETRY_EN
        retry_d    = retry_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rom_addr_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
`ifdef OV7670_CFG_RETRY_EN
                    retry_d    = '0;
`endif
                    state_d    = StFetch;
                end
            end

            // Address held one cycle so the ROM registers the word.
            StFetch: begin
                state_d = StDecode;
            end

            StDecode: begin
                if (rom_data == CFG_END) begin
                    state_d = StFin;
                end else if (rom_data == CFG_DELAY) begin
                    tmr_load = 1'b1;
                    state_d  = StDelay;
                end else begin
                    reg_d   = rom_data[15:8];
                    val_d   = rom_data[7:0];
                    valid_d = 1'b1;
                    state_d = StSend;
                end
            end

            // reg/val only change in StDecode, so they hold while stalled.
            StSend: begin
                if (sccb_ready) begin
                    valid_d = 1'b0;
                    state_d = StWait;
                end
            end

            StWait: begin
                if (sccb_done) begin
                    if (!sccb_nack) begin
                        advance = 1'b1;
                    end else begin
`ifdef OV7670_CFG_RETRY_EN
                        if (retry_q == 2'(MAX_RETRY)) begin
                            state_d = StErr;
                        end else begin
                            retry_d = retry_q + 2'd1;
                            valid_d = 1'b1;
                            state_d = StSend;
                        end
`else
                        state_d = StErr;
`endif
                    end
                end
            end

            StDelay: begin
                if (tmr_expired) begin
                    advance = 1'b1;
                end
            end

            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            StErr: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // No wrap at the end of the ROM: a table without CFG_END still ends.
        if (advance) begin
`ifdef OV7670_CFG_RETRY_EN
            retry_d = '0;
`endif
            if (rom_addr_q == LAST_ADDR) begin
                state_d = StFin;
            end else begin
                rom_addr_d = rom_addr_q + ADDRW'(1);
                state_d    = StFetch;
            end
        end

        // Status flags are visible in the FIN/ERR cycle itself.
        if (state_d == StFin) begin
            done_d = 1'b1;
        end
        if (state_d == StErr) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            reg_q      <= '0;
            val_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            reg_q      <= reg_d;
            val_q      <= val_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

`ifdef OV7670_CFG_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign rom_addr   = rom_addr_q;
    assign sccb_valid = valid_q;
    assign sccb_reg   = reg_q;
    assign sccb_val   = val_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq: synchronous ROM model, SCCB slave model with
// programmable stall and NACK window, and a scoreboard of expected writes.
module tb_ov7670_config_seq;
    import ov7670_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef OV7670_CFG_RETRY_EN
    localparam int RETRIES = 3;
    localparam int RETRY_BUILD = 1;
`else
    localparam int RETRIES = 0;
    localparam int RETRY_BUILD = 0;
`endif

    typedef struct {
        logic [3:0][15:0] w;
        int               stall;
        int               nack_from;
        int               nack_num;
        int               exp_writes;
        logic             exp_done;
        logic             exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_valid;
    logic        sccb_ready = 1'b0;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_val;
    logic        sccb_done = 1'b0;
    logic        sccb_nack = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    logic [15:0] rom [DEPTH];

    always #5 clk = ~clk;

    ov7670_config_seq #(
        .CLK_FREQ_HZ(1000),
        .DELAY_MS   (5),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .sccb_valid(sccb_valid),
        .sccb_ready(sccb_ready),
        .sccb_reg  (sccb_reg),
        .sccb_val  (sccb_val),
        .sccb_done (sccb_done),
        .sccb_nack (sccb_nack),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB slave model. Only this block writes acc_cnt/obs and the slave outputs.
    int          acc_cnt   = 0;
    int          acc_base  = 0;
    int          stall_cfg = 0;
    int          nack_from = 0;
    int          nack_num  = 0;
    int          stall_cnt = 0;
    int          done_tmr  = 0;
    logic        pend_nack = 1'b0;
    logic [15:0] obs [1024];

    always @(posedge clk) begin
        sccb_done <= 1'b0;
        sccb_nack <= 1'b0;
        if (sccb_valid && sccb_ready) begin
            obs[acc_cnt[9:0]] <= {sccb_reg, sccb_val};
            acc_cnt    <= acc_cnt + 1;
            sccb_ready <= 1'b0;
            stall_cnt  <= 0;
            done_tmr   <= 3;
            pend_nack  <= ((acc_cnt - acc_base) >= nack_from) &&
                          ((acc_cnt - acc_base) < (nack_from + nack_num));
        end else if (sccb_valid) begin
            if (stall_cnt >= stall_cfg) sccb_ready <= 1'b1;
            else stall_cnt <= stall_cnt + 1;
        end
        if (done_tmr > 0) begin
            done_tmr <= done_tmr - 1;
            if (done_tmr == 1) begin
                sccb_done <= 1'b1;
                sccb_nack <= pend_nack;
            end
        end
    end

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_q [$];
    vec_t        vecs [7];
    int          last_gap;
    int          last_done_lat;
    int          last_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3,
                                input int stall, input int nf, input int nn,
                                input int nw, input logic d, input logic e);
        vec_t v;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.stall = stall; v.nack_from = nf; v.nack_num = nn;
        v.exp_writes = nw; v.exp_done = d; v.exp_err = e;
        return v;
    endfunction

    // Reference walk of the table: pushes every expected transaction, retries included.
    task automatic build_expect(input vec_t v);
        int   t;
        int   nacks;
        logic stop;
        logic nk;
        t = 0;
        stop = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            if (!stop) begin
                if (v.w[a] == CFG_END) begin
                    stop = 1'b1;
                end else if (v.w[a] != CFG_DELAY) begin
                    nacks = 0;
                    nk = 1'b1;
                    while (nk && !stop) begin
                        exp_q.push_back(v.w[a]);
                        nk = (t >= v.nack_from) && (t < v.nack_from + v.nack_num);
                        t++;
                        if (nk) begin
                            nacks++;
                            if (nacks > RETRIES) stop = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " rom_addr"}, 32'(rom_addr), 32'h0);
        check({tag, " sccb_valid"}, 32'(sccb_valid), 32'h0);
        check({tag, " sccb_reg"}, 32'(sccb_reg), 32'h0);
        check({tag, " sccb_val"}, 32'(sccb_val), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " done"}, 32'(done), 32'h0);
        check({tag, " error"}, 32'(error), 32'h0);
    endtask

    task automatic run_pass(input vec_t v, input string tag, input int poke_addr);
        int          seen;
        int          cyc;
        int          t_addr [4];
        int          t_done;
        int          vio;
        int          held_bad;
        int          stalls;
        logic        prev_hold;
        logic [15:0] prev_rv;
        logic [1:0]  prev_addr;
        logic        poked;
        logic [15:0] e;

        for (int a = 0; a < DEPTH; a++) rom[a] = v.w[a];
        stall_cfg = v.stall;
        nack_from = v.nack_from;
        nack_num  = v.nack_num;
        acc_base  = acc_cnt;
        exp_q.delete();
        build_expect(v);
        seen = acc_cnt;

        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy after start"}, 32'(busy), 32'h1);
        check({tag, " flags cleared"}, {30'h0, done, error}, 32'h0);

        for (int a = 0; a < 4; a++) t_addr[a] = -1;
        t_done = -1; vio = 0; held_bad = 0; stalls = 0;
        prev_hold = 1'b0; prev_rv = '0; prev_addr = rom_addr; poked = 1'b0;
        cyc = 0;
        while (busy && cyc < 2000) begin
            start = 1'b0;
            if (t_addr[rom_addr] < 0) t_addr[rom_addr] = cyc;
            if (done && t_done < 0) t_done = cyc;
            if (rom_addr != prev_addr && sccb_valid) vio++;
            if (prev_hold && (!sccb_valid || {sccb_reg, sccb_val} != prev_rv)) held_bad++;
            if (sccb_valid && !sccb_ready) stalls++;
            prev_hold = sccb_valid && !sccb_ready;
            prev_rv   = {sccb_reg, sccb_val};
            prev_addr = rom_addr;
            while (seen < acc_cnt) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("%s write %0d", tag, seen - acc_base),
                          32'(obs[seen[9:0]]), 32'(e));
                end
                seen++;
            end
            if (poke_addr >= 0 && !poked && int'(rom_addr) == poke_addr) begin
                start = 1'b1;
                poked = 1'b1;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, " pass terminated"}, 32'(cyc < 2000), 32'h1);

        // Trailing window: an aborted pass must not issue further writes.
        repeat (10) tick();
        check({tag, " write count"}, 32'(acc_cnt - acc_base), 32'(v.exp_writes));
        check({tag, " scoreboard drained"}, 32'(exp_q.size()), 32'h0);
        check({tag, " done"}, 32'(done), 32'(v.exp_done));
        check({tag, " error"}, 32'(error), 32'(v.exp_err));
        check({tag, " busy low"}, 32'(busy), 32'h0);
        check({tag, " valid vs addr change"}, 32'(vio), 32'h0);
        check({tag, " request held in stall"}, 32'(held_bad), 32'h0);
        last_gap      = t_addr[2] - t_addr[1];
        last_done_lat = t_done - t_addr[3];
        last_stall    = stalls;
    endtask

    initial begin
        int base;
        int cyc;

        vecs[0] = mk(16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF, 0, 0, 0, 2, 1'b1, 1'b0);
        vecs[1] = mk(16'h1280, 16'h1100, 16'h3A04, 16'h4001, 0, 0, 0, 4, 1'b1, 1'b0);
        vecs[2] = mk(16'h1280, 16'h1100, 16'hFFFF, 16'h0000, 0, 1, 2,
                     RETRY_BUILD ? 4 : 2, RETRY_BUILD ? 1'b1 : 1'b0,
                     RETRY_BUILD ? 1'b0 : 1'b1);
        vecs[3] = mk(16'hAA55, 16'hFFFF, 16'h0000, 16'h0000, 10, 0, 0, 1, 1'b1, 1'b0);
        vecs[4] = mk(16'hFFFF, 16'h1280, 16'h0000, 16'h0000, 0, 0, 0, 0, 1'b1, 1'b0);
        vecs[5] = mk(16'hFFF0, 16'hFFF0, 16'hFFFF, 16'h1280, 0, 0, 0, 0, 1'b1, 1'b0);
        vecs[6] = mk(16'h1280, 16'h1100, 16'hFFFF, 16'h0000, 0, 1, 4,
                     RETRY_BUILD ? 5 : 2, 1'b0, 1'b1);

        rst = 1'b1;
        start = 1'b1;
        for (int a = 0; a < DEPTH; a++) rom[a] = 16'h0000;
        repeat (3) tick();
        check_idle_outputs("reset");
        start = 1'b0;
        rst = 1'b0;
        tick();
        check_idle_outputs("post reset");

        for (int i = 0; i < 7; i++) begin
            run_pass(vecs[i], $sformatf("vec%0d", i), -1);
            if (i == 0) begin
                check("vec0 delay fetch-to-fetch", 32'(last_gap), 32'd7);
                check("vec0 done latency", 32'(last_done_lat), 32'd2);
            end
            if (i == 1) check("vec1 rom_addr stops at last", 32'(rom_addr), 32'd3);
            if (i == 3) check("vec3 stall cycles seen", 32'(last_stall >= 10), 32'h1);
        end

        // start pulsed mid-pass must not restart or add writes.
        run_pass(vecs[1], "start while busy", 2);

        // Reset while waiting for the SCCB transaction to finish.
        for (int a = 0; a < DEPTH; a++) rom[a] = vecs[2].w[a];
        stall_cfg = 0;
        nack_num  = 0;
        acc_base  = acc_cnt;
        base = acc_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (acc_cnt == base && cyc < 100) begin
            tick();
            cyc++;
        end
        check("rst-in-wait accept seen", 32'(acc_cnt - base), 32'd1);
        rst = 1'b1;
        tick();
        check_idle_outputs("rst in wait");
        rst = 1'b0;
        repeat (10) tick();
        check("rst-in-wait no further writes", 32'(acc_cnt - base), 32'd1);
        check("rst-in-wait stays idle", 32'(busy), 32'h0);
        run_pass(mk(16'h1280, 16'h1100, 16'hFFFF, 16'h0000, 0, 0, 0, 2, 1'b1, 1'b0),
                 "restart after rst", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
